ddr2_read_engine: RTL and testbench
===================================

# ddr2_read_engine

Read-side companion to the DDR2 user write logic. It accepts a burst read request (start address, command count) and issues MIG read commands into the address FIFO while respecting `app_af_afull`. It collects the `rd_data_valid` beats into an internal FIFO and presents them on a ready/valid stream, marking the last beat of each request. Command issue is credit-limited, so the MIG read path, which cannot be back-pressured, never overflows the buffer.

## Interface
- `APPDATA_WIDTH`, 128: width of one application data beat.
- `BEATS_PER_CMD`, 2: `rd_data_valid` beats returned per read command. This is BL4 on a 64-bit DDR2 bus.
- `ADDR_STEP`, 4: address increment per command, in column units.
- `FIFO_DEPTH`, 16: read buffer depth. Must be a power of two and ≥ 2×`BEATS_PER_CMD`.
- `LEN_WIDTH`, 8: width of the request command count.

- `clk0`, in, 1: single clock for the block.
- `rst0_n`, in, 1: asynchronous, active-low reset.
- `phy_init_done`, in, 1: MIG calibration complete. No request is accepted while it is low.
- `req_valid`, in, 1: request offered.
- `req_ready`, out, 1: request accepted on `req_valid && req_ready`.
- `req_addr`, in, 31: start address.
- `req_len`, in, `LEN_WIDTH`: number of read commands.
- `app_af_afull`, in, 1: MIG address FIFO almost full.
- `app_af_wren`, out, 1: address FIFO write strobe.
- `app_af_addr`, out, 31: command address.
- `app_af_cmd`, out, 3: command; 3'b001 = read.
- `rd_data_valid`, in, 1: MIG read beat valid.
- `rd_data_fifo_out`, in, `APPDATA_WIDTH`: MIG read beat.
- `dout_valid`, out, 1: output beat valid.
- `dout_ready`, in, 1: downstream accepts the output beat.
- `dout_data`, out, `APPDATA_WIDTH`: output beat.
- `dout_last`, out, 1: marks the final beat of the request.
- `busy`, out, 1: high from request accept until `done`.
- `done`, out, 1: one-cycle pulse when the request completes.
- `rd_err`, out, 1: sticky error flag, cleared only by reset.

## Operation
- **States:**
  - IDLE: `req_ready = phy_init_done`.
  - On accept: latch `req_addr`, set `cmds_left = req_len`, set `beats_left = req_len × BEATS_PER_CMD`.
    - `req_len == 0` → DONE.
    - Otherwise → ISSUE.
  - ISSUE: issue one command per cycle while the issue condition below holds. On issuing the last command → DRAIN.
  - DRAIN: wait until `beats_left == 0`, i.e. the last beat has been popped at the output → DONE.
  - DONE: pulse `done` for one cycle → IDLE.
- **Issue condition:** `!app_af_afull && credits ≥ BEATS_PER_CMD`, where `credits = FIFO_DEPTH − fifo_count − pending`.
  - `pending` counts beats issued but not yet returned.
  - Counter widths are clog2(`FIFO_DEPTH`)+1 bits; credits never go negative.
- **On issue:**
  - Registered outputs for one cycle: `app_af_wren = 1`, `app_af_cmd = 3'b001`, `app_af_addr = cur_addr`.
  - `cur_addr += ADDR_STEP`, modulo 2^31 (wrap-around permitted).
  - `cmds_left−−`; `pending += BEATS_PER_CMD`.
- **Read return:** `rd_data_valid` pushes `rd_data_fifo_out` into the FIFO and decrements `pending`. A same-cycle issue and return nets both changes to `pending`.
- **Output:** first-word-fall-through FIFO. A pop occurs on `dout_valid && dout_ready` and decrements `beats_left`. `dout_last = dout_valid && beats_left == 1`. Simultaneous push and pop is allowed.
- **Error:** `rd_data_valid` arriving with `pending == 0` or with the FIFO full sets `rd_err`, and the beat is dropped.
- **Reset:** asserting `rst0_n` mid-operation clears all state, empties the FIFO and zeroes all counters. Beats still in flight from the MIG after reset are dropped and set `rd_err`.

## Timing
- **Reset values:** `req_ready` 0, `app_af_wren` 0, `app_af_addr` 0, `app_af_cmd` 0, `dout_valid` 0, `dout_data` 0, `dout_last` 0, `busy` 0, `done` 0, `rd_err` 0.
- **`req_ready`:** registered; drops the cycle after accept.
- **First command:** `app_af_wren` rises 1 cycle after accept.
- **Issue rate:** at most one command per cycle. `app_af_afull` is sampled in the cycle the issue decision is made.
- **Read latency through the block:** `rd_data_valid` at cycle N → `dout_valid` at cycle N+1 if the FIFO was empty.
- **`done`:** asserted the cycle after the last-beat pop; `busy` falls in that same cycle.
- **`req_len == 0`:** `done` 1 cycle after accept; no `app_af_wren`.

## Test plan
- **Single command:** `req_addr=32`, `req_len=1`. Required: exactly one `app_af_wren` with addr 32 and cmd 3'b001. Return beats A, B → `dout` shows A then B, `dout_last` on B, then one `done` pulse.
- **Address wrap:** `req_addr=0x7FFFFFFC`, `req_len=5`. Required command addresses: 0x7FFFFFFC, 0x0, 0x4, 0x8, 0xC.
- **Credit stall:** `FIFO_DEPTH=16`, `dout_ready=0`, `req_len=20`, MIG returns all beats. Required: exactly 8 commands issued, then issue stalls with no `rd_err`. Raising `dout_ready` resumes issue; all 40 beats are delivered in order.
- **Address FIFO full:** `app_af_afull` held high for 10 cycles during ISSUE. Required: no `app_af_wren` for the duration; issue resumes the cycle after deassertion with no address skipped.
- **Zero length:** `req_len=0`. Required: `done` 1 cycle after accept, no `app_af_wren`, `busy` low afterwards.
- **Reset and stray beats:** assert `rst0_n` low after 3 of 6 commands issued, then inject a stray `rd_data_valid` after release. Required: all outputs at reset values, `dout_valid` stays 0, `rd_err` = 1.

Source files
------------

// File: rtl/ddr2_read_engine.sv
// Purpose: issue credit-limited DDR2 MIG read commands and buffer the returned beats.
// Latency: rd_data_valid to dout_valid is 1 cycle with an empty buffer; first command 1 cycle after accept.
// Backpressure: dout_ready stalls the output; command issue stops when credits or app_af_afull run out.
//
// Ports:
//   clk0, rst0_n             - clock, asynchronous active-low reset
//   phy_init_done            - MIG calibration complete; gates req_ready
//   req_valid/req_ready      - request handshake; req_addr = start column, req_len = command count
//   app_af_*                 - MIG address FIFO write port (cmd 3'b001 = read)
//   rd_data_valid/_fifo_out  - MIG read return (cannot be back-pressured)
//   dout_valid/ready/data    - output stream; dout_last flags the final beat of the request
//   busy, done, rd_err       - status: request in progress, completion pulse, sticky overflow/stray error

// Generic first-word-fall-through FIFO. DEPTH must be a power of two so the
// pointers wrap naturally.
module ddr2_read_fifo #(
  parameter int WIDTH = 128,
  parameter int DEPTH = 16
) (
  input  logic                     clk0,
  input  logic                     rst0_n,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_dat,
  input  logic                     pop,
  output logic [WIDTH-1:0]         pop_dat,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == FULL_CNT);
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  // Forced to zero when empty so the output bus is clean out of reset.
  assign pop_dat = empty ? '0 : mem[rd_ptr];

  always_ff @(posedge clk0) begin
    if (do_push) mem[wr_ptr] <= push_dat;
  end

  always_ff @(posedge clk0 or negedge rst0_n) begin
    if (!rst0_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: ;
      endcase
    end
  end
endmodule

module ddr2_read_engine #(
  parameter int APPDATA_WIDTH = 128,
  parameter int BEATS_PER_CMD = 2,
  parameter int ADDR_STEP     = 4,
  parameter int FIFO_DEPTH    = 16,   // power of two, >= 2*BEATS_PER_CMD
  parameter int LEN_WIDTH     = 8
) (
  input  logic                     clk0,
  input  logic                     rst0_n,
  input  logic                     phy_init_done,
  input  logic                     req_valid,
  output logic                     req_ready,
  input  logic [30:0]              req_addr,
  input  logic [LEN_WIDTH-1:0]     req_len,
  input  logic                     app_af_afull,
  output logic                     app_af_wren,
  output logic [30:0]              app_af_addr,
  output logic [2:0]               app_af_cmd,
  input  logic                     rd_data_valid,
  input  logic [APPDATA_WIDTH-1:0] rd_data_fifo_out,
  output logic                     dout_valid,
  input  logic                     dout_ready,
  output logic [APPDATA_WIDTH-1:0] dout_data,
  output logic                     dout_last,
  output logic                     busy,
  output logic                     done,
  output logic                     rd_err
);
  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  localparam int BW = LEN_WIDTH + $clog2(BEATS_PER_CMD);

  localparam logic [CW-1:0]        BPC_C     = CW'(BEATS_PER_CMD);
  localparam logic [CW:0]          DEPTH_C   = (CW+1)'(FIFO_DEPTH);
  localparam logic [30:0]          STEP_C    = 31'(ADDR_STEP);
  localparam logic [2:0]           CMD_READ  = 3'b001;
  localparam logic [LEN_WIDTH-1:0] LEN_ONE   = LEN_WIDTH'(1);
  localparam logic [BW-1:0]        BEATS_ONE = BW'(1);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_DRAIN, S_DONE} state_t;

  state_t               state;
  state_t               state_nxt;
  logic [LEN_WIDTH-1:0] cmds_left;
  logic [BW-1:0]        beats_left;
  logic [30:0]          cur_addr;
  logic [30:0]          issue_addr;
  logic [CW-1:0]        pending;
  logic [CW-1:0]        fifo_count;
  logic [CW:0]          committed;
  logic                 fifo_full;
  logic                 fifo_empty;
  logic                 accept;
  logic                 credit_ok;
  logic                 issue;
  logic                 ret_ok;
  logic                 push;
  logic                 pop;

  assign accept = req_valid && req_ready;

  // credits >= BEATS_PER_CMD, rearranged so nothing can underflow.
  assign committed = {1'b0, fifo_count} + {1'b0, pending} + {1'b0, BPC_C};
  assign credit_ok = (committed <= DEPTH_C);

  // A beat is only owed to us while pending is non-zero; anything else is stray.
  assign ret_ok = rd_data_valid && (pending != '0);
  assign push   = ret_ok && !fifo_full;
  assign pop    = dout_valid && dout_ready;

  assign dout_valid = !fifo_empty;
  assign dout_last  = dout_valid && (beats_left == BEATS_ONE);
  assign busy       = (state == S_ISSUE) || (state == S_DRAIN);
  assign done       = (state == S_DONE);

  ddr2_read_fifo #(
    .WIDTH (APPDATA_WIDTH),
    .DEPTH (FIFO_DEPTH)
  ) u_rd_fifo (
    .clk0     (clk0),
    .rst0_n   (rst0_n),
    .push     (push),
    .push_dat (rd_data_fifo_out),
    .pop      (pop),
    .pop_dat  (dout_data),
    .count    (fifo_count),
    .full     (fifo_full),
    .empty    (fifo_empty)
  );

  // The first command is decided in the accept cycle itself (using req_addr
  // directly) so app_af_wren can rise one cycle after the handshake.
  always_comb begin
    state_nxt  = state;
    issue      = 1'b0;
    issue_addr = cur_addr;
    case (state)
      S_IDLE: begin
        if (accept) begin
          issue_addr = req_addr;
          if (req_len == '0) begin
            state_nxt = S_DONE;
          end else begin
            issue     = !app_af_afull && credit_ok;
            state_nxt = (issue && (req_len == LEN_ONE)) ? S_DRAIN : S_ISSUE;
          end
        end
      end
      S_ISSUE: begin
        issue = (cmds_left != '0) && !app_af_afull && credit_ok;
        if (issue && (cmds_left == LEN_ONE)) state_nxt = S_DRAIN;
      end
      S_DRAIN: begin
        // Leave on the last-beat pop so done lands the very next cycle.
        if ((beats_left == '0) || (pop && (beats_left == BEATS_ONE))) state_nxt = S_DONE;
      end
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk0 or negedge rst0_n) begin
    if (!rst0_n) begin
      state       <= S_IDLE;
      req_ready   <= 1'b0;
      cmds_left   <= '0;
      beats_left  <= '0;
      cur_addr    <= '0;
      pending     <= '0;
      app_af_wren <= 1'b0;
      app_af_addr <= '0;
      app_af_cmd  <= '0;
      rd_err      <= 1'b0;
    end else begin
      state       <= state_nxt;
      req_ready   <= phy_init_done && (state_nxt == S_IDLE);
      app_af_wren <= issue;
      if (issue) begin
        app_af_addr <= issue_addr;
        app_af_cmd  <= CMD_READ;
      end

      // Address wraps modulo 2^31 by virtue of the 31-bit register.
      if (issue)       cur_addr <= issue_addr + STEP_C;
      else if (accept) cur_addr <= req_addr;

      if (accept)     cmds_left <= req_len - LEN_WIDTH'(issue);
      else if (issue) cmds_left <= cmds_left - LEN_ONE;

      if (accept)
        beats_left <= BW'(req_len) * BW'(BEATS_PER_CMD);
      else if (pop && (beats_left != '0))
        beats_left <= beats_left - BEATS_ONE;

      pending <= pending + (issue ? BPC_C : '0) - (ret_ok ? CW'(1) : '0);

      if (rd_data_valid && ((pending == '0) || fifo_full)) rd_err <= 1'b1;
    end
  end
endmodule

// File: tb/tb_ddr2_read_engine.sv
`timescale 1ns/1ps
module tb_ddr2_read_engine;
  logic         clk0;
  logic         rst0_n;
  logic         phy_init_done;
  logic         req_valid;
  logic         req_ready;
  logic [30:0]  req_addr;
  logic [7:0]   req_len;
  logic         app_af_afull;
  logic         app_af_wren;
  logic [30:0]  app_af_addr;
  logic [2:0]   app_af_cmd;
  logic         rd_data_valid;
  logic [127:0] rd_data_fifo_out;
  logic         dout_valid;
  logic         dout_ready;
  logic [127:0] dout_data;
  logic         dout_last;
  logic         busy;
  logic         done;
  logic         rd_err;

  ddr2_read_engine dut (
    .clk0             (clk0),
    .rst0_n           (rst0_n),
    .phy_init_done    (phy_init_done),
    .req_valid        (req_valid),
    .req_ready        (req_ready),
    .req_addr         (req_addr),
    .req_len          (req_len),
    .app_af_afull     (app_af_afull),
    .app_af_wren      (app_af_wren),
    .app_af_addr      (app_af_addr),
    .app_af_cmd       (app_af_cmd),
    .rd_data_valid    (rd_data_valid),
    .rd_data_fifo_out (rd_data_fifo_out),
    .dout_valid       (dout_valid),
    .dout_ready       (dout_ready),
    .dout_data        (dout_data),
    .dout_last        (dout_last),
    .busy             (busy),
    .done             (done),
    .rd_err           (rd_err)
  );

  initial begin
    clk0 = 1'b0;
    forever #5 clk0 = ~clk0;
  end

  int cyc = 0;
  initial forever begin
    @(posedge clk0);
    cyc++;
  end

  // Observation logs, written only by the monitor.
  logic [33:0]  cmd_log[$];
  int           cmd_cyc[$];
  logic [128:0] out_log[$];
  int           out_cyc[$];
  int           done_cyc[$];
  int           rdv_cyc[$];

  initial forever begin
    @(negedge clk0);
    if (app_af_wren) begin
      cmd_log.push_back({app_af_cmd, app_af_addr});
      cmd_cyc.push_back(cyc);
    end
    if (dout_valid && dout_ready) begin
      out_log.push_back({dout_last, dout_data});
      out_cyc.push_back(cyc);
    end
    if (done) done_cyc.push_back(cyc);
    if (rd_data_valid) rdv_cyc.push_back(cyc);
  end

  function automatic logic [127:0] mkdata(input logic [30:0] a, input int k);
    return {32'hC0DE_0000, 1'b0, a, 32'h0000_BEEF, 32'(k)};
  endfunction

  // MIG read-return model: two beats per logged command, in order.
  bit          mig_en = 1'b1;
  int          flush_tok = 0;
  int          stray_tok = 0;
  int          flush_seen = 0;
  int          stray_seen = 0;
  int          mig_idx = 0;
  int          mig_beat = 0;
  logic [30:0] mig_addr = '0;

  initial begin
    rd_data_valid    = 1'b0;
    rd_data_fifo_out = '0;
    forever begin
      @(posedge clk0);
      #2;
      if (flush_tok != flush_seen) begin
        flush_seen = flush_tok;
        mig_idx    = cmd_log.size();
        mig_beat   = 0;
      end
      if (mig_beat == 0 && mig_en && mig_idx < cmd_log.size()) begin
        mig_addr = cmd_log[mig_idx][30:0];
        mig_idx++;
        mig_beat = 2;
      end
      if (stray_seen != stray_tok) begin
        stray_seen++;
        rd_data_valid    = 1'b1;
        rd_data_fifo_out = {4{32'hDEAD_BEEF}};
      end else if (mig_beat != 0) begin
        rd_data_valid    = 1'b1;
        rd_data_fifo_out = mkdata(mig_addr, 2 - mig_beat);
        mig_beat--;
      end else begin
        rd_data_valid    = 1'b0;
        rd_data_fifo_out = '0;
      end
    end
  end

  int n_chk = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick_n();
    @(negedge clk0);
    #1;
  endtask

  // Holds req_valid until the handshake; returns the accept cycle.
  task automatic do_accept(output bit got, output int acc);
    got = 1'b0;
    acc = 0;
    for (int t = 0; t < 50 && !got; t++) begin
      tick_n();
      if (req_ready) begin
        got = 1'b1;
        acc = cyc;
      end
    end
    chk("accept", got, 1);
    @(posedge clk0);
    #1;
    req_valid = 1'b0;
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_req_ready"}, req_ready, 0);
    chk({tag, "_wren"}, app_af_wren, 0);
    chk({tag, "_af_addr"}, app_af_addr, 0);
    chk({tag, "_af_cmd"}, app_af_cmd, 0);
    chk({tag, "_dout_valid"}, dout_valid, 0);
    chk({tag, "_dout_data_nz"}, dout_data != '0, 0);
    chk({tag, "_dout_last"}, dout_last, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_rd_err"}, rd_err, 0);
  endtask

  typedef struct {
    logic [30:0] addr;
    logic [7:0]  len;
    bit          hold_ready;
    bit          afull_test;
    int          exp_cmds;
    logic [30:0] exp_first;
    logic [30:0] exp_last;
    int          exp_beats;
  } vec_t;

  vec_t vecs[5];

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    bit          got;
    int          acc;
    int          cb;
    int          ob;
    int          db;
    int          rb;
    int          c_af;
    int          n;
    int          bad;
    int          t;
    logic [30:0] exp_a;
    logic [128:0] exp_d;

    vecs[0] = '{31'h20,       8'd1,  1'b0, 1'b0, 1,  31'h20,       31'h20,  2};
    vecs[1] = '{31'h7FFFFFFC, 8'd5,  1'b0, 1'b0, 5,  31'h7FFFFFFC, 31'h0C,  10};
    vecs[2] = '{31'h100,      8'd20, 1'b1, 1'b0, 20, 31'h100,      31'h14C, 40};
    vecs[3] = '{31'h2000,     8'd6,  1'b0, 1'b1, 6,  31'h2000,     31'h2014, 12};
    vecs[4] = '{31'h40,       8'd0,  1'b0, 1'b0, 0,  31'h40,       31'h40,  0};

    rst0_n        = 1'b0;
    phy_init_done = 1'b0;
    req_valid     = 1'b0;
    req_addr      = '0;
    req_len       = '0;
    app_af_afull  = 1'b0;
    dout_ready    = 1'b1;

    repeat (3) tick_n();
    chk_reset_vals("rst");
    rst0_n = 1'b1;
    repeat (3) tick_n();
    chk("no_ready_before_init", req_ready, 0);
    phy_init_done = 1'b1;
    repeat (2) tick_n();

    for (int v = 0; v < 5; v++) begin
      cb = cmd_log.size();
      ob = out_log.size();
      db = done_cyc.size();
      rb = rdv_cyc.size();
      c_af = 0;
      @(posedge clk0);
      #1;
      dout_ready = !vecs[v].hold_ready;
      req_addr   = vecs[v].addr;
      req_len    = vecs[v].len;
      req_valid  = 1'b1;
      do_accept(got, acc);
      tick_n();
      chk("req_ready_drop", req_ready, 0);
      chk("busy_on", busy, vecs[v].len != 0);

      if (vecs[v].afull_test) begin
        t = 0;
        while (cmd_log.size() - cb < 2 && t < 50) begin
          tick_n();
          t++;
        end
        @(posedge clk0);
        #1;
        app_af_afull = 1'b1;
        c_af = cyc;
        repeat (10) @(posedge clk0);
        #1;
        app_af_afull = 1'b0;
      end

      if (vecs[v].hold_ready) begin
        repeat (60) tick_n();
        chk("stall_cmds", cmd_log.size() - cb, 8);
        chk("stall_rd_err", rd_err, 0);
        chk("stall_dout_valid", dout_valid, 1);
        @(posedge clk0);
        #1;
        dout_ready = 1'b1;
      end

      t = 0;
      while (done_cyc.size() == db && t < 3000) begin
        tick_n();
        t++;
      end
      chk("done_seen", done_cyc.size() - db, 1);
      repeat (3) tick_n();
      chk("done_once", done_cyc.size() - db, 1);
      chk("busy_off", busy, 0);
      chk("rd_err_clean", rd_err, 0);

      n = cmd_log.size() - cb;
      chk("cmd_count", n, vecs[v].exp_cmds);
      bad = 0;
      for (int i = 0; i < n; i++) begin
        exp_a = vecs[v].exp_first + 31'(4 * i);
        if (cmd_log[cb + i] !== {3'b001, exp_a}) bad++;
      end
      chk("cmd_seq_bad", bad, 0);
      if (n > 0) begin
        chk("cmd_last_addr", cmd_log[cb + n - 1][30:0], vecs[v].exp_last);
        if (!vecs[v].afull_test) chk("first_cmd_latency", cmd_cyc[cb] - acc, 1);
      end

      if (vecs[v].afull_test) begin
        bad = 0;
        got = 1'b0;
        for (int i = cb; i < cmd_log.size(); i++) begin
          if (cmd_cyc[i] > c_af && cmd_cyc[i] <= c_af + 10) bad++;
          if (cmd_cyc[i] == c_af + 11) got = 1'b1;
        end
        chk("afull_quiet", bad, 0);
        chk("afull_resume", got, 1);
      end

      n = out_log.size() - ob;
      chk("beat_count", n, vecs[v].exp_beats);
      bad = 0;
      for (int j = 0; j < n; j++) begin
        exp_d = {(j == vecs[v].exp_beats - 1),
                 mkdata(vecs[v].exp_first + 31'(4 * (j / 2)), j % 2)};
        if (out_log[ob + j] !== exp_d) bad++;
      end
      chk("beat_seq_bad", bad, 0);
      if (done_cyc.size() > db) begin
        if (n > 0) chk("done_after_last_pop", done_cyc[db] - out_cyc[ob + n - 1], 1);
        else       chk("done_zero_len", done_cyc[db] - acc, 1);
      end
      if (n > 0 && !vecs[v].hold_ready && rdv_cyc.size() > rb)
        chk("read_latency", out_cyc[ob] - rdv_cyc[rb], 1);
    end

    // Reset mid-request, then a stray beat from the MIG.
    cb = cmd_log.size();
    @(posedge clk0);
    #1;
    mig_en     = 1'b0;
    dout_ready = 1'b1;
    req_addr   = 31'h500;
    req_len    = 8'd6;
    req_valid  = 1'b1;
    do_accept(got, acc);
    t = 0;
    while (cmd_log.size() - cb < 3 && t < 50) begin
      tick_n();
      t++;
    end
    chk("pre_reset_cmds", cmd_log.size() - cb >= 3, 1);
    rst0_n = 1'b0;
    #2;
    chk_reset_vals("midrst");
    repeat (2) tick_n();
    rst0_n = 1'b1;
    flush_tok++;
    @(posedge clk0);
    #1;
    stray_tok++;
    n = 0;
    repeat (6) begin
      tick_n();
      if (dout_valid) n++;
    end
    chk("stray_dout_valid", n, 0);
    chk("stray_rd_err", rd_err, 1);
    chk("stray_busy", busy, 0);
    chk("stray_wren", app_af_wren, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
